// File: rtl/histo_link_pkg.sv
// Shared definitions for the camera histogram SPI link (serializer and
// deserializer sides).
//   - Word framing: four bytes per 32-bit word.
//   - Byte order: least-significant byte first on the wire.
//   - Bit order: MSB first within each byte.
//   - SPI mode 0: data is sampled on SCLK rising edges.
package histo_link_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_BITS  = 8;
    localparam int WORD_BITS  = WORD_BYTES * BYTE_BITS;
    localparam int SPI_MODE   = 0;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } order_e;

    localparam order_e BYTE_ORDER = LSB_FIRST;
    localparam order_e BIT_ORDER  = MSB_FIRST;

    // One-cycle status pulses produced by the receiver.
    typedef struct packed {
        logic word_done;
        logic overrun;
        logic frame_error;
    } link_evt_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous link pin, with rising-edge
// detect on the synchronized level.
//   clk_i   : fast sampling clock
//   rst_i   : synchronous active-high reset
//   pin_i   : asynchronous pin
//   sync_o  : synchronized level (STAGES flops deep)
//   rise_o  : combinational, high for one cycle after sync_o goes 0->1
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic sync_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_o & ~prev_q;

endmodule

// File: rtl/histo_deserializer.sv
// Receive side of the histogram SPI link. Oversamples SCLK/MOSI in the
// fast clock domain and rebuilds 32-bit words (LSB byte first, MSB bit
// first), presented on a single-entry ready/valid register.
//   fast_clk_in : system clock, >= 4x SCLK
//   reset       : synchronous active-high reset
//   sclk_in     : SPI clock (async, idles low)
//   mosi_in     : SPI data (async)
//   data_out    : assembled word, first byte in [7:0]
//   data_valid  : data_out holds an unconsumed word
//   data_ready  : downstream accept
//   word_done   : pulse per completed word (accepted or dropped)
//   overrun     : pulse when a word completes while the register is full
//   frame_error : pulse when idle timeout discards a partial word
//   debug       : {byte index, byte being shifted}
module histo_deserializer
    import histo_link_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 64,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 fast_clk_in,
    input  logic                 reset,
    input  logic                 sclk_in,
    input  logic                 mosi_in,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 word_done,
    output logic                 overrun,
    output logic                 frame_error,
    output logic [9:0]           debug
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    typedef logic [TW-1:0] timer_t;
    localparam timer_t TIMEOUT = timer_t'(IDLE_TIMEOUT);

    logic sclk_s, rise, mosi_s, mosi_rise_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i  (fast_clk_in),
        .rst_i  (reset),
        .pin_i  (sclk_in),
        .sync_o (sclk_s),
        .rise_o (rise)
    );

    // Same depth as SCLK so data and its sampling edge stay aligned.
    spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk_i  (fast_clk_in),
        .rst_i  (reset),
        .pin_i  (mosi_in),
        .sync_o (mosi_s),
        .rise_o (mosi_rise_unused)
    );

    logic [4:0]           bit_cnt_q,  bit_cnt_d;
    logic [BYTE_BITS-1:0] shift_q,    shift_d;
    logic [WORD_BITS-1:0] word_q,     word_d;
    logic [WORD_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    timer_t               idle_q,     idle_d;
    link_evt_t            evt_q,      evt_d;

    logic [BYTE_BITS-1:0] byte_full;
    logic [WORD_BITS-1:0] word_full;
    logic                 word_cmpl;

    // The byte including the bit being sampled this cycle; the final byte
    // of a word goes straight into the output so no extra cycle is spent.
    assign byte_full = {shift_q[BYTE_BITS-2:0], mosi_s};
    assign word_full = {byte_full, word_q[WORD_BITS-BYTE_BITS-1:0]};

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        data_d    = data_q;
        valid_d   = valid_q;
        idle_d    = idle_q;
        evt_d     = '0;
        word_cmpl = 1'b0;

        if (rise) begin
            shift_d   = byte_full;
            bit_cnt_d = bit_cnt_q + 5'd1;
            idle_d    = '0;
            if (bit_cnt_q[2:0] == 3'd7)
                word_d[BYTE_BITS*bit_cnt_q[4:3] +: BYTE_BITS] = byte_full;
            word_cmpl = (bit_cnt_q == 5'd31);
        end else if (idle_q != TIMEOUT) begin
            idle_d = idle_q + timer_t'(1);
        end else if (bit_cnt_q != 5'd0) begin
            // Fires once: bit_cnt is zero afterwards until the next rise.
            bit_cnt_d         = '0;
            shift_d           = '0;
            evt_d.frame_error = 1'b1;
        end

        if (word_cmpl) begin
            evt_d.word_done = 1'b1;
            if (!valid_q || data_ready) begin
                data_d  = word_full;
                valid_d = 1'b1;
            end else begin
                evt_d.overrun = 1'b1;
            end
        end else if (data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge fast_clk_in) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            idle_q    <= '0;
            evt_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            idle_q    <= idle_d;
            evt_q     <= evt_d;
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign word_done   = evt_q.word_done;
    assign overrun     = evt_q.overrun;
    assign frame_error = evt_q.frame_error;
    assign debug       = {bit_cnt_q[4:3], shift_q};

endmodule

// File: tb/tb_histo_deserializer.sv
module tb_histo_deserializer;

    localparam int IDLE_TIMEOUT = 64;

    logic        fast_clk_in = 1'b0;
    logic        reset       = 1'b1;
    logic        sclk_in     = 1'b0;
    logic        mosi_in     = 1'b0;
    logic        data_ready  = 1'b0;
    logic [31:0] data_out;
    logic        data_valid, word_done, overrun, frame_error;
    logic [9:0]  debug;

    histo_deserializer #(.IDLE_TIMEOUT(IDLE_TIMEOUT), .SYNC_STAGES(2)) dut (
        .fast_clk_in (fast_clk_in),
        .reset       (reset),
        .sclk_in     (sclk_in),
        .mosi_in     (mosi_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .word_done   (word_done),
        .overrun     (overrun),
        .frame_error (frame_error),
        .debug       (debug)
    );

    always #5 fast_clk_in = ~fast_clk_in;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0, n_ovr = 0, n_ferr = 0, n_vcyc = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge fast_clk_in);
            #1;
        end
    endtask

    // Serializer model: 4 fast clocks per half-bit, LSB byte first, MSB bit
    // first. With hs_last, data_ready is high only in the cycle where the
    // last bit's rise is seen (two edges after SCLK is driven high).
    task automatic send_bits(input logic [31:0] w, input int nbits, input bit hs_last);
        for (int i = 0; i < nbits; i++) begin
            mosi_in = w[8*(i/8) + 7 - (i%8)];
            sclk_in = 1'b0;
            tick(4);
            sclk_in = 1'b1;
            if (hs_last && i == nbits-1) begin
                tick(2);
                data_ready = 1'b1;
                tick(1);
                data_ready = 1'b0;
                tick(1);
            end else begin
                tick(4);
            end
        end
        sclk_in = 1'b0;
    endtask

    // Monitor: counts pulses and pops the scoreboard on every accepted word.
    always @(negedge fast_clk_in) begin
        if (!reset) begin
            if (word_done)   n_done++;
            if (overrun)     n_ovr++;
            if (frame_error) n_ferr++;
            if (data_valid)  n_vcyc++;
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL accept_unexpected: got %h expected none", data_out);
                end else begin
                    chk("accepted_word", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] word;
        int          exp_done;
        int          exp_vcyc;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int d0, o0, f0, v0;
        logic [31:0] w;

        vecs[0] = '{32'hDEADBEEF, 1, 1};
        vecs[1] = '{32'h00000000, 1, 1};
        vecs[2] = '{32'hFFFFFFFF, 1, 1};
        vecs[3] = '{32'h80000001, 1, 1};
        vecs[4] = '{32'hA5A55A5A, 1, 1};

        // Reset state
        tick(5);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", {31'b0, data_valid}, 32'h0);
        chk("rst_pulses", {29'b0, word_done, overrun, frame_error}, 32'h0);
        chk("rst_debug", {22'b0, debug}, 32'h0);
        reset = 1'b0;
        tick(3);

        // Table: single words with data_ready held high
        data_ready = 1'b1;
        foreach (vecs[k]) begin
            d0 = n_done; v0 = n_vcyc; o0 = n_ovr;
            exp_q.push_back(vecs[k].word);
            send_bits(vecs[k].word, 32, 1'b0);
            tick(10);
            chk("tbl_word_done", n_done - d0, vecs[k].exp_done);
            chk("tbl_valid_cycles", n_vcyc - v0, vecs[k].exp_vcyc);
            chk("tbl_data_out", data_out, vecs[k].word);
            chk("tbl_overrun", n_ovr - o0, 0);
        end

        // Overrun: second word dropped while first is held
        data_ready = 1'b0;
        d0 = n_done; o0 = n_ovr;
        exp_q.push_back(32'h01234567);
        send_bits(32'h01234567, 32, 1'b0);
        send_bits(32'h89ABCDEF, 32, 1'b0);
        tick(5);
        chk("ovr_count", n_ovr - o0, 1);
        chk("ovr_word_done", n_done - d0, 2);
        chk("ovr_data_held", data_out, 32'h01234567);
        chk("ovr_valid", {31'b0, data_valid}, 32'h1);
        data_ready = 1'b1;
        tick(1);
        chk("ovr_valid_falls", {31'b0, data_valid}, 32'h0);

        // Truncated frame then a clean word
        f0 = n_ferr;
        send_bits(32'h12345678, 20, 1'b0);
        tick(IDLE_TIMEOUT + 5);
        chk("ferr_once", n_ferr - f0, 1);
        chk("ferr_debug_clr", {22'b0, debug}, 32'h0);
        d0 = n_done;
        exp_q.push_back(32'hCAFEF00D);
        send_bits(32'hCAFEF00D, 32, 1'b0);
        tick(10);
        chk("ferr_next_word", data_out, 32'hCAFEF00D);
        chk("ferr_next_done", n_done - d0, 1);
        chk("ferr_still_once", n_ferr - f0, 1);

        // Accept in the exact completion cycle: new word loads, no overrun
        data_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(32'h11112222);
        send_bits(32'h11112222, 32, 1'b0);
        exp_q.push_back(32'h33334444);
        send_bits(32'h33334444, 32, 1'b1);
        tick(2);
        chk("sim_no_overrun", n_ovr - o0, 0);
        chk("sim_valid_stays", {31'b0, data_valid}, 32'h1);
        chk("sim_new_word", data_out, 32'h33334444);
        data_ready = 1'b1;
        tick(2);
        chk("sim_drained", {31'b0, data_valid}, 32'h0);

        // Reset after two bytes
        f0 = n_ferr;
        send_bits(32'hFFFFFFFF, 16, 1'b0);
        reset = 1'b1;
        tick(2);
        chk("midrst_debug", {22'b0, debug}, 32'h0);
        chk("midrst_data_out", data_out, 32'h0);
        reset = 1'b0;
        tick(2);
        exp_q.push_back(32'h00000001);
        send_bits(32'h00000001, 32, 1'b0);
        tick(IDLE_TIMEOUT + 10);
        chk("midrst_word", data_out, 32'h00000001);
        chk("midrst_no_ferr", n_ferr - f0, 0);

        // Back-to-back random words
        d0 = n_done; o0 = n_ovr; f0 = n_ferr;
        for (int k = 0; k < 150; k++) begin
            w = $urandom;
            exp_q.push_back(w);
            send_bits(w, 32, 1'b0);
        end
        tick(10);
        chk("rand_done", n_done - d0, 150);
        chk("rand_no_ovr", n_ovr - o0, 0);
        chk("rand_no_ferr", n_ferr - f0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
